// File: rtl/change_dispenser.sv
// Change dispenser: runs the product motor for a vend, then ejects the owed
// coins one at a time and waits for each coin to be confirmed by the exit
// sensor. A missing confirmation ends in a sticky fault that only reset clears.
module change_dispenser #(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 2,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend,
  input  logic [1:0] change,
  input  logic       coin_ack,
  output logic       motor_on,
  output logic       coin_eject,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic       req_dropped,
  output logic [1:0] coins_left
);

  localparam logic [7:0] PulseCnt   = 8'(PULSE_LEN);
  localparam logic [7:0] GapCnt     = 8'(GAP_LEN);
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StVend,
    StVgap,
    StEject,
    StWaitAck,
    StCgap,
    StDone,
    StFault
  } state_e;

  state_e     state;
  logic [7:0] cnt;       // cycles remaining in the current timed state
  logic       ack_seen;  // coin_ack caught during EJECT, consumed in WAIT_ACK
  logic       req;

  assign req = vend | (change != 2'b00);

  // State, counters and all outputs; outputs are set on the transition into
  // the state they belong to so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      cnt         <= 8'd0;
      ack_seen    <= 1'b0;
      motor_on    <= 1'b0;
      coin_eject  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      req_dropped <= 1'b0;
      coins_left  <= 2'd0;
    end else begin
      done        <= 1'b0;
      req_dropped <= req && (state != StIdle);
      case (state)
        StIdle: begin
          if (req) begin
            coins_left <= change;
            ack_seen   <= 1'b0;
            cnt        <= PulseCnt;
            busy       <= 1'b1;
            if (vend) begin
              state    <= StVend;
              motor_on <= 1'b1;
            end else begin
              state      <= StEject;
              coin_eject <= 1'b1;
            end
          end
        end

        StVend: begin
          if (cnt == 8'd1) begin
            state    <= StVgap;
            cnt      <= GapCnt;
            motor_on <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        // Both gaps end the same way: next coin if any are owed, else finish.
        StVgap, StCgap: begin
          if (cnt == 8'd1) begin
            if (coins_left != 2'd0) begin
              state      <= StEject;
              cnt        <= PulseCnt;
              coin_eject <= 1'b1;
              ack_seen   <= 1'b0;
            end else begin
              state <= StDone;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        StEject: begin
          // Any number of acks during the pulse collapse into one.
          if (coin_ack) begin
            ack_seen <= 1'b1;
          end
          if (cnt == 8'd1) begin
            state      <= StWaitAck;
            cnt        <= TimeoutCnt;
            coin_eject <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        StWaitAck: begin
          if (coin_ack || ack_seen) begin
            ack_seen   <= 1'b0;
            coins_left <= coins_left - 2'd1;
            state      <= StCgap;
            cnt        <= GapCnt;
          end else if (cnt == 8'd1) begin
            state <= StFault;
            fault <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end

        // Sticky: actuators stay off until reset.
        StFault: begin
          motor_on   <= 1'b0;
          coin_eject <= 1'b0;
          fault      <= 1'b1;
        end

        default: begin
          state      <= StIdle;
          motor_on   <= 1'b0;
          coin_eject <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed cycle-exact checks plus a scoreboard
// that compares each completed request's actuator activity to expectations.
module tb_change_dispenser;

  logic       clk;
  logic       rst;
  logic       vend;
  logic [1:0] change;
  logic       coin_ack;
  logic       motor_on;
  logic       coin_eject;
  logic       busy;
  logic       done;
  logic       fault;
  logic       req_dropped;
  logic [1:0] coins_left;

  logic ack_auto;
  logic ack_manual;
  int   ack_delay;  // cycles from eject end to sensor ack; <=0 means no auto ack
  int   ack_cd;

  assign coin_ack = ack_auto | ack_manual;

  change_dispenser #(
    .PULSE_LEN(4),
    .GAP_LEN  (2),
    .TIMEOUT  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vend       (vend),
    .change     (change),
    .coin_ack   (coin_ack),
    .motor_on   (motor_on),
    .coin_eject (coin_eject),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .req_dropped(req_dropped),
    .coins_left (coins_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int motor_cyc;
    int eject_pulses;
    int eject_cyc;
    int coin_trail;  // coins_left values in order of change, one hex digit each
    int is_fault;
  } exp_t;

  exp_t q[$];
  int   n_tests;
  int   n_fail;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  // Monitor: accumulate activity between completions and score it.
  int   m_cyc, e_cyc, e_pul, trail, overlap;
  logic prev_ej, prev_fault;
  logic [1:0] prev_coins;

  always @(negedge clk) begin
    if (rst) begin
      m_cyc = 0; e_cyc = 0; e_pul = 0; trail = 0; overlap = 0;
      prev_ej = 1'b0; prev_fault = 1'b0; prev_coins = 2'd0;
      q.delete();
    end else begin
      if (motor_on) m_cyc++;
      if (coin_eject) e_cyc++;
      if (coin_eject && !prev_ej) e_pul++;
      if (motor_on && coin_eject) overlap = 1;
      if (coins_left != prev_coins) trail = trail * 16 + int'(coins_left);
      if (done || (fault && !prev_fault)) begin
        check_eq("sb_pending", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check_eq("sb_motor_cyc", m_cyc, e.motor_cyc);
          check_eq("sb_eject_pulses", e_pul, e.eject_pulses);
          check_eq("sb_eject_cyc", e_cyc, e.eject_cyc);
          check_eq("sb_coin_trail", trail, e.coin_trail);
          check_eq("sb_fault", int'(fault), e.is_fault);
          check_eq("sb_overlap", overlap, 0);
        end
        m_cyc = 0; e_cyc = 0; e_pul = 0; trail = 0; overlap = 0;
      end
      prev_ej    = coin_eject;
      prev_fault = fault;
      prev_coins = coins_left;
    end
  end

  // Coin sensor model: one ack pulse ack_delay cycles after each eject pulse.
  logic resp_prev_ej;
  always @(negedge clk) begin
    ack_auto = (ack_cd == 1);
    if (ack_cd > 0) ack_cd--;
    if (resp_prev_ej && !coin_eject && ack_delay > 0) ack_cd = ack_delay;
    resp_prev_ej = coin_eject;
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((busy || q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_timeout", int'(n < max_cyc), 1);
  endtask

  task automatic push_exp(input int mc, input int ep, input int ec, input int tr,
                          input int fl);
    exp_t e;
    e.motor_cyc = mc; e.eject_pulses = ep; e.eject_cyc = ec;
    e.coin_trail = tr; e.is_fault = fl;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_motor[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    int exp_busy[8]  = '{1, 1, 1, 1, 1, 1, 1, 0};
    int exp_done[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};

    n_tests = 0; n_fail = 0;
    rst = 1'b1; vend = 1'b0; change = 2'd0;
    ack_manual = 1'b0; ack_auto = 1'b0; ack_delay = 0; ack_cd = 0;
    resp_prev_ej = 1'b0;
    wait_cycles(3);

    // Reset state
    check_eq("rst_motor", int'(motor_on), 0);
    check_eq("rst_eject", int'(coin_eject), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_fault", int'(fault), 0);
    check_eq("rst_coins", int'(coins_left), 0);
    rst = 1'b0;

    // vend=0, change=0 is not a request
    wait_cycles(3);
    check_eq("noreq_busy", int'(busy), 0);

    // Vend only: exact pulse timing
    @(negedge clk);
    vend = 1'b1;
    push_exp(4, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vend = 1'b0;
      check_eq($sformatf("v0_motor_t%0d", k + 1), int'(motor_on), exp_motor[k]);
      check_eq($sformatf("v0_busy_t%0d", k + 1), int'(busy), exp_busy[k]);
      check_eq($sformatf("v0_done_t%0d", k + 1), int'(done), exp_done[k]);
    end
    wait_idle(50);

    // Request during VEND is dropped, original completes unchanged
    @(negedge clk);
    vend = 1'b1;
    push_exp(4, 0, 0, 0, 0);
    @(negedge clk);
    vend = 1'b0;
    @(negedge clk);
    vend = 1'b1;
    change = 2'd2;
    @(negedge clk);
    vend = 1'b0;
    change = 2'd0;
    check_eq("drop_pulse", int'(req_dropped), 1);
    @(negedge clk);
    check_eq("drop_clear", int'(req_dropped), 0);
    check_eq("drop_coins", int'(coins_left), 0);
    wait_idle(50);

    // Vend with three coins, sensor acks two cycles after each eject
    ack_delay = 2;
    @(negedge clk);
    vend = 1'b1;
    change = 2'd3;
    push_exp(4, 3, 12, 'h3210, 0);
    @(negedge clk);
    vend = 1'b0;
    change = 2'd0;
    wait_idle(200);

    // Fast sensor: ack in 2nd EJECT cycle is latched
    ack_delay = 0;
    @(negedge clk);
    change = 2'd1;
    push_exp(0, 1, 4, 'h10, 0);
    @(negedge clk);  // EJECT cycle 1
    change = 2'd0;
    @(negedge clk);  // EJECT cycle 2
    ack_manual = 1'b1;
    @(negedge clk);
    ack_manual = 1'b0;
    @(negedge clk);
    @(negedge clk);  // WAIT_ACK
    check_eq("fast_wait_coins", int'(coins_left), 1);
    check_eq("fast_wait_eject", int'(coin_eject), 0);
    @(negedge clk);  // CGAP
    check_eq("fast_cgap_coins", int'(coins_left), 0);
    wait_cycles(2);
    check_eq("fast_done", int'(done), 1);
    wait_idle(50);

    // Reset mid-EJECT, then a request on the first edge after release
    ack_delay = 2;
    @(negedge clk);
    change = 2'd2;
    push_exp(0, 0, 0, 0, 0);  // aborted by reset; discarded by the monitor
    @(negedge clk);
    change = 2'd0;
    @(negedge clk);
    check_eq("mid_eject_on", int'(coin_eject), 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_eject", int'(coin_eject), 0);
    check_eq("mid_rst_coins", int'(coins_left), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    vend = 1'b1;
    push_exp(4, 0, 0, 0, 0);
    @(negedge clk);
    vend = 1'b0;
    check_eq("post_rst_motor", int'(motor_on), 1);
    wait_idle(50);

    // No ack ever: fault after 16 WAIT_ACK cycles, sticky
    ack_delay = 0;
    @(negedge clk);
    change = 2'd1;
    push_exp(0, 1, 4, 'h1, 1);
    @(negedge clk);  // EJECT cycle 1
    change = 2'd0;
    wait_cycles(19);  // last WAIT_ACK cycle
    check_eq("to_fault_early", int'(fault), 0);
    @(negedge clk);
    check_eq("to_fault_set", int'(fault), 1);
    check_eq("to_busy", int'(busy), 1);
    vend = 1'b1;
    @(negedge clk);
    vend = 1'b0;
    wait_cycles(6);
    check_eq("flt_motor", int'(motor_on), 0);
    check_eq("flt_eject", int'(coin_eject), 0);
    check_eq("flt_sticky", int'(fault), 1);
    check_eq("flt_sb_drained", int'(q.size()), 0);
    rst = 1'b1;
    #1;
    check_eq("flt_rst_clear", int'(fault), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
